// File: rtl/wb_commit_if.sv
// Handshake bundle between x2/fr and the writeback/commit stage.
// Upstream drives the x2 slot and read indices; commit drives the rest.
interface wb_commit_if #(
  parameter int CNT_W = 32
);
  logic             x2_valid;
  logic [15:0]      x2_ins;
  logic [15:0]      x2_pc;
  logic [15:0]      x2_result;
  logic [15:0]      x2_operand_2;
  logic [3:0]       rd_addr_a;
  logic [3:0]       rd_addr_b;
  logic [15:0]      rd_data_a;
  logic [15:0]      rd_data_b;
  logic             flush;
  logic [15:0]      redirect_pc;
  logic             mem_wen;
  logic [15:0]      mem_waddr;
  logic [15:0]      mem_wdata;
  logic             print_valid;
  logic [7:0]       print_char;
  logic             halted;
  logic [CNT_W-1:0] retired_count;

  modport master (
    output x2_valid, x2_ins, x2_pc,
    output x2_result, x2_operand_2,
    output rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b,
    input  flush, redirect_pc,
    input  mem_wen, mem_waddr, mem_wdata,
    input  print_valid, print_char,
    input  halted, retired_count
  );

  modport slave (
    input  x2_valid, x2_ins, x2_pc,
    input  x2_result, x2_operand_2,
    input  rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b,
    output flush, redirect_pc,
    output mem_wen, mem_waddr, mem_wdata,
    output print_valid, print_char,
    output halted, retired_count
  );
endinterface

// File: rtl/wb_commit.sv
// Writeback/commit stage: register file, stores, jump squash,
// r0 print port and halt.
module wb_commit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic          clk,
  input  logic          reset,
  wb_commit_if.slave    bus
);

  typedef enum logic [1:0] {
    RUN,
    SQUASH,
    HALTED
  } state_e;

  localparam logic [2:0] SQ_INIT = 3'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [15:0]      rf_q [16];
  logic             flush_q, flush_d;
  logic [15:0]      redir_q, redir_d;
  logic             wen_q, wen_d;
  logic [15:0]      waddr_q, waddr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             pv_q, pv_d;
  logic [7:0]       pch_q, pch_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  logic [3:0]  op, sub, rt;
  logic [15:0] pc_plus2;
  logic        commit, taken, rf_we;
  logic        is_wr, is_st, is_jmp, is_halt;

  assign op       = bus.x2_ins[15:12];
  assign sub      = bus.x2_ins[7:4];
  assign rt       = bus.x2_ins[3:0];
  assign pc_plus2 = bus.x2_pc + 16'd2;
  assign commit   = bus.x2_valid && (state_q == RUN);
  assign taken    = is_jmp && (bus.x2_result != pc_plus2);
  assign rf_we    = commit && is_wr && (rt != 4'd0);

  always_comb begin
    is_wr   = 1'b0;
    is_st   = 1'b0;
    is_jmp  = 1'b0;
    is_halt = 1'b0;
    unique case (op)
      4'h0, 4'h1, 4'h2,
      4'h3, 4'h7, 4'hE: is_wr   = 1'b1;
      4'h4, 4'hC, 4'hD: is_st   = (sub == 4'h1);
      4'h6:             is_jmp  = 1'b1;
      4'hF:             is_halt = 1'b1;
      default: ;
    endcase
  end

  // Same-cycle commit wins over the stored value
  always_comb begin
    bus.rd_data_a = rf_q[bus.rd_addr_a];
    bus.rd_data_b = rf_q[bus.rd_addr_b];
    if (rf_we && rt == bus.rd_addr_a)
      bus.rd_data_a = bus.x2_result;
    if (rf_we && rt == bus.rd_addr_b)
      bus.rd_data_b = bus.x2_result;
    if (bus.rd_addr_a == 4'd0)
      bus.rd_data_a = '0;
    if (bus.rd_addr_b == 4'd0)
      bus.rd_data_b = '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    redir_d = redir_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    pv_d    = 1'b0;
    pch_d   = pch_q;
    halt_d  = halt_q;
    ret_d   = ret_q;
    unique case (state_q)
      RUN: begin
        flush_d = 1'b0;
        if (commit) begin
          ret_d = ret_q + CNT_W'(1);
          if (is_wr && rt == 4'd0) begin
            pv_d  = 1'b1;
            pch_d = bus.x2_result[7:0];
          end
          if (is_st) begin
            wen_d   = 1'b1;
            waddr_d = bus.x2_operand_2;
            wdata_d = bus.x2_result;
          end
          if (taken) begin
            state_d = SQUASH;
            cnt_d   = SQ_INIT;
            flush_d = 1'b1;
            redir_d = bus.x2_result;
          end
          if (is_halt) begin
            state_d = HALTED;
            halt_d  = 1'b1;
          end
        end
      end
      SQUASH: begin
        if (cnt_q == 3'd0) begin
          state_d = RUN;
          flush_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      HALTED: flush_d = 1'b0;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      redir_q <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      pv_q    <= 1'b0;
      pch_q   <= '0;
      halt_q  <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      redir_q <= redir_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      pv_q    <= pv_d;
      pch_q   <= pch_d;
      halt_q  <= halt_d;
      ret_q   <= ret_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++)
        rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rt] <= bus.x2_result;
    end
  end

  assign bus.flush         = flush_q;
  assign bus.redirect_pc   = redir_q;
  assign bus.mem_wen       = wen_q;
  assign bus.mem_waddr     = waddr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.print_valid   = pv_q;
  assign bus.print_char    = pch_q;
  assign bus.halted        = halt_q;
  assign bus.retired_count = ret_q;

endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
- Writeback/commit stage directly downstream of the two-stage ALU (x, x2).
- Consumes the x2 outputs and owns the 16x16 architectural register file; it serves the fr stage's two read ports with write-through bypass.
- Performs stores, resolves jumps into a flush plus redirect, drives the r0 print port, and halts the core.
- Wrong-path instructions are squashed for a fixed window after a taken jump.

Parameters:
- FLUSH_CYCLES, 2, number of x2 slots squashed after a taken jump, counting the first cycle flush is high (range 1..7).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- x2_valid  input  1  x2 slot holds a live instruction.
- x2_ins  input  16  instruction; opcode [15:12], ra [11:8], rb/subcode [7:4], rt [3:0].
- x2_pc  input  16  PC of x2 instruction.
- x2_result  input  16  ALU result / loaded value / next PC for jumps / store data.
- x2_operand_2  input  16  second operand; store address for stores.
- rd_addr_a  input  4  fr read port A index.
- rd_addr_b  input  4  fr read port B index.
- rd_data_a  output  16  combinational read data, port A.
- rd_data_b  output  16  combinational read data, port B.
- flush  output  1  registered; squash fr/x stages this cycle.
- redirect_pc  output  16  registered jump target, valid while flush=1.
- mem_wen  output  1  registered store strobe.
- mem_waddr  output  16  store address.
- mem_wdata  output  16  store data.
- print_valid  output  1  registered one-cycle pulse on a write to r0.
- print_char  output  8  low byte of the value written to r0.
- halted  output  1  core halted.
- retired_count  output  CNT_W  committed instruction count.

Behaviour:
- Reset (async, active-high): all outputs are 0; state=RUN; squash counter=0; registers r1..r15=0.
- Commit condition: x2_valid && state==RUN. When the condition is false, the slot is a no-op: no register write, store, print, redirect or count increment.
- Writes to rt:
  - Opcodes 0000, 0001, 0010, 0011, 1110 and 0111 (ld) write x2_result to rt at the commit edge.
  - rt==0 does not write; it pulses print_valid with print_char=x2_result[7:0] on the next cycle.
- Reads:
  - Index 0 reads 0.
  - Otherwise the read returns the register value; if the same-cycle commit targets that rt (rt!=0), it returns x2_result (bypass).
- Stores:
  - Opcode 0100, 1100 or 1101 with subcode 1 is a store.
  - Next cycle: mem_wen=1, mem_waddr=x2_operand_2, mem_wdata=x2_result.
  - No register write.
  - mem_wen is a single-cycle pulse per store.
- Jumps:
  - Opcode 0110 is a jump; it is taken iff x2_result != x2_pc+2 (16-bit wrap).
  - Taken jump: next cycle flush=1 and redirect_pc=x2_result; state goes to SQUASH with counter=FLUSH_CYCLES-1.
  - Not-taken jump: commits with no side effect.
- Halt: opcode 1111 commits, then halted=1 and state=HALTED; HALTED is sticky until reset.
- Retired count: retired_count increments by 1 for each committed instruction, including jumps and halt. It wraps at 2^CNT_W.
- State machine:
  - RUN -> SQUASH on a taken jump.
  - RUN -> HALTED on halt.
  - SQUASH: flush=1 every cycle, x2 slots are ignored, counter decrements each cycle; SQUASH -> RUN after the cycle in which counter==0.
  - With FLUSH_CYCLES=1, flush is high for exactly one cycle.
  - HALTED: flush=0, no commits.
- Flush and redirect_pc hold their values for the whole SQUASH window. A jump arriving inside the window is ignored; it is wrong-path.
- A reset asserted mid-SQUASH or mid-HALTED returns to RUN immediately; any pending store or print pulse is cancelled.
- Undefined opcodes (0101, 1000-1011) commit as no-ops and count as retired.

Test Plan:
- Arithmetic and bypass: x2 add, rt=3, result 0x1234, rd_addr_a=3 in the same cycle -> rd_data_a=0x1234 that cycle; after the edge r3=0x1234; retired_count=1.
- Print: x2 sub with rt=0, result 0x0141 -> one-cycle print_valid, print_char=0x41; rd_data of r0 stays 0.
- Store: opcode 0100, subcode 1, result 0xBEEF, operand_2 0x0040 -> next cycle mem_wen=1, addr 0x0040, data 0xBEEF; one-cycle pulse; no register change.
- Taken jump: pc 0x0010, result 0x0100, followed by two valid adds to r5 -> flush=1 for 2 cycles, redirect_pc=0x0100, r5 unchanged, retired_count +1.
- Not-taken jump: pc 0x0010, result 0x0012 -> flush stays 0 and the next add commits. Wrap case: pc 0xFFFE, result 0x0000 -> not taken.
- Halt then reset: halt commits and halted=1; a later add to r2 is ignored; asynchronous reset mid-cycle -> halted=0 and r2=0 immediately, without waiting for a clock edge.
